// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl
// Scans N_SENSORS read channels one at a time. Each channel is selected for
// SETTLE_CYCLES cycles and then sampled on three consecutive cycles. The
// majority-voted result and a disagreement flag are offered on a
// valid/ready port. Completed scans and accepted faulty results are counted.
// An abort returns the block to IDLE at any point and discards work in flight.

module sensor_scan_ctrl #(
    parameter int N_SENSORS     = 8,   // channels scanned, 2..32
    parameter int SETTLE_CYCLES = 4    // select-to-sample settle time, 1..255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    input  logic [N_SENSORS-1:0] sens_in,
    output logic [N_SENSORS-1:0] sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_idx,
    output logic                 out_bit,
    output logic                 out_fault,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          scan_count,
    output logic [7:0]           fault_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT
    } state_t;

    // One-hot select for channel 0; other channels are shifted from this.
    localparam logic [N_SENSORS-1:0] SEL_ONE     = N_SENSORS'(1);
    localparam logic [4:0]           LAST_IDX    = 5'(N_SENSORS - 1);
    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    // Three samples are taken; the counter runs 2,1,0 across them.
    localparam logic [7:0]           SAMPLE_LAST = 8'd2;

    // State and registered outputs
    state_t                 state_q;
    logic [4:0]             idx_q;
    logic [7:0]             cnt_q;
    logic [1:0]             samp_q;
    logic [N_SENSORS-1:0]   sel_q;
    logic                   out_valid_q;
    logic [4:0]             out_idx_q;
    logic                   out_bit_q;
    logic                   out_fault_q;
    logic                   busy_q;
    logic                   done_q;
    logic [15:0]            scan_count_q;
    logic [7:0]             fault_count_q;

    // Combinational helpers feeding the state register
    logic                   cur_bit_d;
    logic                   last_ch_d;
    logic                   hs_d;
    logic [4:0]             nxt_idx_d;
    logic [N_SENSORS-1:0]   nxt_sel_d;
    logic                   vote_bit_d;
    logic                   vote_fault_d;

    // Derive the selected sensor level, the next channel and the 2-of-3 vote.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no
        // latch can be inferred; add new outputs with a default at the top.
        // sel_q is one-hot on the active channel while sampling, so masking
        // and OR-reducing picks that channel without a variable bit index.
        cur_bit_d    = |(sens_in & sel_q);
        last_ch_d    = (idx_q == LAST_IDX);
        hs_d         = out_valid_q & out_ready;
        nxt_idx_d    = last_ch_d ? 5'd0 : idx_q + 5'd1;
        nxt_sel_d    = SEL_ONE << nxt_idx_d;
        vote_bit_d   = (samp_q[1] & samp_q[0])
                     | (samp_q[1] & cur_bit_d)
                     | (samp_q[0] & cur_bit_d);
        vote_fault_d = ~((samp_q[1] == samp_q[0]) && (samp_q[0] == cur_bit_d));
    end

    // Scan sequencer: state, channel index, timers, result and counters.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked
        // block and takes effect only on a rising edge; it overrides abort
        // and every other input.
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= 5'd0;
            cnt_q         <= 8'd0;
            samp_q        <= 2'b00;
            sel_q         <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= 5'd0;
            out_bit_q     <= 1'b0;
            out_fault_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            scan_count_q  <= 16'd0;
            fault_count_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the pre-edge value of each register.
            done_q <= 1'b0;

            if (abort) begin
                // Abort wins over start and handshake: drop everything and
                // leave the counters untouched.
                state_q     <= IDLE;
                idx_q       <= 5'd0;
                sel_q       <= '0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= SETTLE;
                            idx_q   <= 5'd0;
                            sel_q   <= SEL_ONE;
                            cnt_q   <= SETTLE_LAST;
                            busy_q  <= 1'b1;
                        end
                    end

                    SETTLE: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= SAMPLE;
                            cnt_q   <= SAMPLE_LAST;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end

                    SAMPLE: begin
                        if (cnt_q == 8'd0) begin
                            // Third sample is used live in the vote, so the
                            // result is ready the cycle REPORT begins.
                            state_q     <= REPORT;
                            sel_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_idx_q   <= idx_q;
                            out_bit_q   <= vote_bit_d;
                            out_fault_q <= vote_fault_d;
                        end else begin
                            samp_q <= {samp_q[0], cur_bit_d};
                            cnt_q  <= cnt_q - 8'd1;
                        end
                    end

                    REPORT: begin
                        // Outputs hold until the consumer takes the result.
                        if (hs_d) begin
                            out_valid_q <= 1'b0;
                            if (out_fault_q && (fault_count_q != 8'hFF)) begin
                                fault_count_q <= fault_count_q + 8'd1;
                            end
                            if (last_ch_d) begin
                                done_q       <= 1'b1;
                                scan_count_q <= scan_count_q + 16'd1;
                            end
                            if (!last_ch_d || continuous) begin
                                state_q <= SETTLE;
                                idx_q   <= nxt_idx_d;
                                sel_q   <= nxt_sel_d;
                                cnt_q   <= SETTLE_LAST;
                            end else begin
                                state_q <= IDLE;
                                idx_q   <= 5'd0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel         = sel_q;
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign out_bit     = out_bit_q;
    assign out_fault   = out_fault_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign scan_count  = scan_count_q;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Bench for sensor_scan_ctrl: an event-time reference model predicts the
// cycle-level outputs and pushes each expected result into a queue; a monitor
// compares every cycle and pops the queue whenever the DUT presents a result.

module tb_sensor_scan_ctrl;

    localparam int N = 8;
    localparam int S = 4;

    typedef struct {
        logic [4:0] idx;
        logic       vbit;
        logic       fault;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] sens_in = '0;
    logic [N-1:0] sel;
    logic         out_valid;
    logic [4:0]   out_idx;
    logic         out_bit;
    logic         out_fault;
    logic         busy;
    logic         done;
    logic [15:0]  scan_count;
    logic [7:0]   fault_count;

    sensor_scan_ctrl #(.N_SENSORS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .abort(abort), .sens_in(sens_in), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_bit(out_bit),
        .out_fault(out_fault), .busy(busy), .done(done),
        .scan_count(scan_count), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;          // number of rising edges so far
    bit         m_active = 0;     // a scan is in progress
    bit         m_valid = 0;      // a result is on offer
    bit         m_done = 0;
    bit         m_cur_fault = 0;
    int         m_idx = 0;
    int         m_report_edge = 0; // edge at which the third sample is taken
    logic [15:0] m_scans = 0;
    int         m_faults = 0;
    bit         smp [3];
    res_t       exp_q [$];

    task automatic model_step();
        int   ones;
        res_t r;
        m_done = 0;
        if (rst) begin
            m_active = 0; m_valid = 0; m_idx = 0;
            m_scans = 0; m_faults = 0;
            exp_q.delete();
        end else if (abort) begin
            m_active = 0; m_valid = 0; m_idx = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_idx = 0;
                m_report_edge = cyc + S + 3;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                if (m_cur_fault && m_faults < 255) m_faults++;
                if (m_idx == N - 1) begin
                    m_done = 1;
                    m_scans = m_scans + 16'd1;
                    if (continuous) begin
                        m_idx = 0; m_report_edge = cyc + S + 3;
                    end else begin
                        m_active = 0; m_idx = 0;
                    end
                end else begin
                    m_idx++;
                    m_report_edge = cyc + S + 3;
                end
            end
        end else if (cyc >= m_report_edge - 2) begin
            smp[cyc - (m_report_edge - 2)] = sens_in[m_idx];
            if (cyc == m_report_edge) begin
                ones = int'(smp[0]) + int'(smp[1]) + int'(smp[2]);
                r.idx   = 5'(m_idx);
                r.vbit  = (ones >= 2);
                r.fault = (ones != 0) && (ones != 3);
                m_cur_fault = r.fault;
                exp_q.push_back(r);
                m_valid = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    int   done_seen = 0;
    int   last_done_cyc = -1;
    int   first_pres_cyc = -1;
    int   n_results = 0;
    logic res_bit   [32];
    logic res_fault [32];

    initial begin
        bit           prev_valid = 0;
        logic         rdy_edge;
        res_t         cur;
        logic [N-1:0] exp_sel;
        forever begin
            @(posedge clk);
            rdy_edge = out_ready;
            #1;
            exp_sel = (m_active && !m_valid) ? (N'(1) << m_idx) : '0;
            check($sformatf("cycle_state@%0d", cyc),
                  {out_valid, busy, done, sel, scan_count, fault_count},
                  {m_valid, m_active, m_done, exp_sel, m_scans, 8'(m_faults)});
            if (done === 1'b1) begin
                done_seen++;
                last_done_cyc = cyc;
            end
            if (out_valid === 1'b1) begin
                if (!prev_valid || rdy_edge) begin
                    check($sformatf("sb_pending@%0d", cyc), 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check($sformatf("sb_result@%0d", cyc),
                              {out_idx, out_bit, out_fault}, {cur.idx, cur.vbit, cur.fault});
                        res_bit[out_idx]   = out_bit;
                        res_fault[out_idx] = out_fault;
                        n_results++;
                        if (first_pres_cyc < 0) first_pres_cyc = cyc;
                    end
                end else begin
                    check($sformatf("sb_hold@%0d", cyc),
                          {out_idx, out_bit, out_fault}, {cur.idx, cur.vbit, cur.fault});
                end
            end
            prev_valid = (out_valid === 1'b1);
        end
    end

    // ---------------- sensor driver ----------------
    int           sens_mode  = 0;   // 0 fixed, 1 random, 2 toggle, 3 ch2 pattern
    logic [N-1:0] sens_fixed = '0;
    int           ch2_first  = 0;

    initial forever begin
        @(negedge clk);
        case (sens_mode)
            0:       sens_in = sens_fixed;
            1:       sens_in = N'($urandom);
            2:       sens_in = ~sens_in;
            default: begin
                sens_in    = '0;
                sens_in[2] = (cyc + 1 == ch2_first);
            end
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int n = 0;
        while (done_seen < target && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_done_reached"}, 64'(done_seen >= target), 64'd1);
    endtask

    task automatic pulse_start(output int e);
        e = cyc + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int           e;
        int           base;
        int           held;
        int           n;
        logic [7:0]   fc0;
        logic [N-1:0] bits_v;
        logic [N-1:0] faults_v;

        // Reset values
        repeat (3) tick();
        check("reset_outputs",
              {out_idx, out_bit, out_fault, out_valid, busy, done, sel, scan_count, fault_count}, '0);
        rst = 1'b0;
        tick();

        // Single scan of a static 0xA5 pattern with ready held high
        sens_mode = 0; sens_fixed = 8'hA5; out_ready = 1'b1;
        first_pres_cyc = -1; n_results = 0;
        pulse_start(e);
        wait_idle(200, "scan_a5");
        check("a5_first_valid_edge", 64'(first_pres_cyc), 64'(e + S + 3));
        check("a5_done_edge", 64'(last_done_cyc), 64'(e + N * (S + 4)));
        check("a5_result_count", 64'(n_results), 64'(N));
        for (int i = 0; i < N; i++) begin
            bits_v[i]   = res_bit[i];
            faults_v[i] = res_fault[i];
        end
        check("a5_bits", 64'(bits_v), 64'h00A5);
        check("a5_faults", 64'(faults_v), 64'h0);

        // Channel 2 sees 1,0,0 across its three samples
        fc0 = fault_count;
        sens_mode = 3;
        e = cyc + 1;
        ch2_first = e + S + 1 + 2 * (S + 4);
        pulse_start(e);
        wait_idle(200, "ch2_toggle");
        check("ch2_bit", 64'(res_bit[2]), 64'd0);
        check("ch2_fault", 64'(res_fault[2]), 64'd1);
        check("ch2_fault_count_delta", 64'(8'(fault_count - fc0)), 64'd1);

        // Back-pressure: hold ready low for 10 cycles of REPORT
        sens_mode = 1; out_ready = 1'b0;
        pulse_start(e);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("stall_valid_seen", 64'(out_valid), 64'd1);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1 && sel === '0) held++;
            tick();
        end
        check("stall_held_cycles", 64'(held), 64'd10);
        out_ready = 1'b1;
        wait_idle(300, "stall_scan");

        // Continuous mode for three scans
        base = done_seen;
        continuous = 1'b1;
        pulse_start(e);
        wait_done(base + 2, 400, "cont");
        continuous = 1'b0;
        wait_idle(400, "cont");
        check("cont_done_pulses", 64'(done_seen - base), 64'd3);

        // Abort during SAMPLE of channel 5, then restart
        base = done_seen;
        pulse_start(e);
        while (cyc + 1 < e + S + 2 + 5 * (S + 4)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_done", 64'(done_seen - base), 64'd0);
        pulse_start(e);
        wait_idle(200, "restart");

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            start     = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            abort     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 199) == 0) continuous = ~continuous;
            tick();
        end
        start = 1'b0; abort = 1'b0; continuous = 1'b0; out_ready = 1'b1;
        wait_idle(600, "random_drain");

        // Every sample window disagrees: saturate the fault counter
        sens_mode = 2; continuous = 1'b1;
        base = done_seen;
        pulse_start(e);
        wait_done(base + 33, 33 * (N * (S + 4)) + 200, "saturate");
        continuous = 1'b0;
        wait_idle(200, "saturate");
        check("fault_count_saturated", 64'(fault_count), 64'd255);

        // Reset in the middle of SETTLE
        pulse_start(e);
        tick();
        rst = 1'b1;
        tick();
        check("midsettle_reset_outputs",
              {out_idx, out_bit, out_fault, out_valid, busy, done, sel, scan_count, fault_count}, '0);
        rst = 1'b0;
        repeat (S + 8) tick();
        check("midsettle_no_activity", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on run length
    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=%0d required<%0d", cyc, 30000);
        $fatal(1, "watchdog expired");
    end

endmodule
